// File: rtl/rriot_bus_arbiter.sv
// Two-requester arbiter/sequencer for the shared mcs6530 bus.
// Bounded-burst round-robin grant, one transaction at a time, one-cycle ack.
module rriot_bus_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m0_we_n,
    input  logic       m0_rs0,
    input  logic [9:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we_n,
    input  logic       m1_rs0,
    input  logic [9:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       bus_we_n,
    output logic       bus_rs0,
    output logic [9:0] bus_addr,
    output logic [7:0] bus_di,
    input  logic [7:0] bus_do,
    output logic       bus_active,
    output logic       owner
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
    localparam logic [2:0] LAT       = 3'(RD_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t     r_state, w_next;
    logic       r_we_n, r_rs0, r_owner;
    logic [9:0] r_addr;
    logic [7:0] r_di, r_rdata0, r_rdata1;
    logic [3:0] r_burst;
    logic [2:0] r_wcnt;

    logic       w_grant, w_win;
    logic       w_sel_we_n, w_sel_rs0;
    logic [9:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    // Burst count only breaks ties; a lone requester always wins.
    always_comb begin
        w_grant = m0_req | m1_req;
        w_win   = m1_req;
        if (m0_req && m1_req)
            w_win = (r_burst < BURST_MAX) ? r_owner : ~r_owner;
        w_sel_we_n  = w_win ? m1_we_n  : m0_we_n;
        w_sel_rs0   = w_win ? m1_rs0   : m0_rs0;
        w_sel_addr  = w_win ? m1_addr  : m0_addr;
        w_sel_wdata = w_win ? m1_wdata : m0_wdata;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_next = S_ACCESS;
            S_ACCESS: w_next = r_we_n ? S_WAIT : S_RESP;
            S_WAIT:   if (r_wcnt == LAT) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_we_n   <= 1'b1;
            r_rs0    <= 1'b0;
            r_addr   <= '0;
            r_di     <= '0;
            r_owner  <= 1'b1;
            r_burst  <= BURST_MAX;
            r_wcnt   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_we_n  <= w_sel_we_n;
                    r_rs0   <= w_sel_rs0;
                    r_addr  <= w_sel_addr;
                    r_di    <= w_sel_wdata;
                    r_owner <= w_win;
                    if (w_win != r_owner)        r_burst <= 4'd1;
                    else if (r_burst != BURST_MAX) r_burst <= r_burst + 4'd1;
                end
                S_ACCESS: r_wcnt <= 3'd1;
                S_WAIT: begin
                    if (r_wcnt == LAT) begin
                        if (r_owner) r_rdata1 <= bus_do;
                        else         r_rdata0 <= bus_do;
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe and acks decode from state so reset clears them without waiting for an edge.
    assign bus_we_n   = !((r_state == S_ACCESS) && !r_we_n);
    assign bus_active = (r_state == S_ACCESS) || (r_state == S_WAIT);
    assign m0_ack     = (r_state == S_RESP) && !r_owner;
    assign m1_ack     = (r_state == S_RESP) &&  r_owner;
    assign bus_rs0    = r_rs0;
    assign bus_addr   = r_addr;
    assign bus_di     = r_di;
    assign owner      = r_owner;
    assign m0_rdata   = r_rdata0;
    assign m1_rdata   = r_rdata1;

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// Directed bench for rriot_bus_arbiter: three instances (defaults, RD_LATENCY=3, MAX_BURST=1)
// share stimulus; each section checks the instance whose parameters it targets.
module tb_rriot_bus_arbiter;

    logic phi2 = 1'b0;
    logic rst_n = 1'b0;
    logic       m0_req, m0_we_n, m0_rs0, m1_req, m1_we_n, m1_rs0;
    logic [9:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata, bus_do;

    logic [2:0]       m0_ack, m1_ack, bus_we_n, bus_rs0, bus_active, owner;
    logic [2:0][7:0]  m0_rdata, m1_rdata, bus_di;
    logic [2:0][9:0]  bus_addr;

    int errors = 0;
    int checks = 0;

    always #5 phi2 = ~phi2;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rriot_bus_arbiter #(
            .RD_LATENCY((g == 1) ? 3 : 1),
            .MAX_BURST ((g == 2) ? 1 : 4)
        ) u_dut (
            .phi2(phi2), .rst_n(rst_n),
            .m0_req(m0_req), .m0_we_n(m0_we_n), .m0_rs0(m0_rs0), .m0_addr(m0_addr),
            .m0_wdata(m0_wdata), .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req), .m1_we_n(m1_we_n), .m1_rs0(m1_rs0), .m1_addr(m1_addr),
            .m1_wdata(m1_wdata), .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
            .bus_we_n(bus_we_n[g]), .bus_rs0(bus_rs0[g]), .bus_addr(bus_addr[g]),
            .bus_di(bus_di[g]), .bus_do(bus_do), .bus_active(bus_active[g]), .owner(owner[g])
        );
    end

    typedef struct {
        logic       req, we, rs;
        logic [9:0] addr;
        logic [7:0] wd, bdo;
        logic       e_we_n, e_act;
        logic [9:0] e_addr;
        logic [7:0] e_di;
        logic       e_ack;
        logic [7:0] e_rd;
        logic       e_own, e_rs;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge phi2); #1;
    endtask

    task automatic smp();
        @(negedge phi2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 0; m0_we_n = 1; m0_rs0 = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we_n = 1; m1_rs0 = 0; m1_addr = '0; m1_wdata = '0;
        bus_do = '0;
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        int   seq_a[$], seq_c[$];
        int   exp_a[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int   exp_c[6] = '{0, 1, 0, 1, 0, 1};
        bit   dual, ok, seen, m0seen, acked;
        int   k, n, at;

        // m0 write 0xA5 to 0x3C0 (rs0=1), then read it back (RD_LATENCY=1)
        //          req we rs addr    wd     bdo   | we_n act addr    di     ack rd     own rs
        tv[0] = '{1, 0, 1, 10'h3C0, 8'hA5, 8'h00, 1, 0, 10'h000, 8'h00, 0, 8'h00, 1, 0};
        tv[1] = '{1, 0, 1, 10'h3C0, 8'hA5, 8'h00, 0, 1, 10'h3C0, 8'hA5, 0, 8'h00, 0, 1};
        tv[2] = '{1, 0, 1, 10'h3C0, 8'hA5, 8'h00, 1, 0, 10'h3C0, 8'hA5, 1, 8'h00, 0, 1};
        tv[3] = '{1, 1, 1, 10'h3C0, 8'h00, 8'h00, 1, 0, 10'h3C0, 8'hA5, 0, 8'h00, 0, 1};
        tv[4] = '{1, 1, 1, 10'h3C0, 8'h00, 8'h00, 1, 1, 10'h3C0, 8'h00, 0, 8'h00, 0, 1};
        tv[5] = '{1, 1, 1, 10'h3C0, 8'h00, 8'hA5, 1, 1, 10'h3C0, 8'h00, 0, 8'h00, 0, 1};
        tv[6] = '{1, 1, 1, 10'h3C0, 8'h00, 8'hA5, 1, 0, 10'h3C0, 8'h00, 1, 8'hA5, 0, 1};
        tv[7] = '{0, 1, 1, 10'h3C0, 8'h00, 8'h00, 1, 0, 10'h3C0, 8'h00, 0, 8'hA5, 0, 1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            m0_req = tv[i].req; m0_we_n = tv[i].we; m0_rs0 = tv[i].rs;
            m0_addr = tv[i].addr; m0_wdata = tv[i].wd; bus_do = tv[i].bdo;
            smp();
            chk($sformatf("wr_rd[%0d] bus_we_n", i), bus_we_n[0], tv[i].e_we_n);
            chk($sformatf("wr_rd[%0d] bus_active", i), bus_active[0], tv[i].e_act);
            chk($sformatf("wr_rd[%0d] bus_addr", i), bus_addr[0], tv[i].e_addr);
            chk($sformatf("wr_rd[%0d] bus_di", i), bus_di[0], tv[i].e_di);
            chk($sformatf("wr_rd[%0d] bus_rs0", i), bus_rs0[0], tv[i].e_rs);
            chk($sformatf("wr_rd[%0d] m0_ack", i), m0_ack[0], tv[i].e_ack);
            chk($sformatf("wr_rd[%0d] m1_ack", i), m1_ack[0], 1'b0);
            chk($sformatf("wr_rd[%0d] m0_rdata", i), m0_rdata[0], tv[i].e_rd);
            chk($sformatf("wr_rd[%0d] owner", i), owner[0], tv[i].e_own);
            cyc();
        end

        // RD_LATENCY=3: prior m0 read leaves 0x11, then m1 read of 0x155
        do_reset();
        bus_do = 8'h11; m0_req = 1; m0_we_n = 1; m0_addr = 10'h010;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            smp();
            if (m0_ack[1]) ok = 1;
            else cyc();
        end
        chk("lat3 prior ack seen", ok, 1'b1);
        chk("lat3 prior m0_rdata", m0_rdata[1], 8'h11);
        cyc();
        m0_req = 0;
        m1_req = 1; m1_we_n = 1; m1_rs0 = 1; m1_addr = 10'h155; bus_do = 8'h00;
        cyc();
        smp();
        chk("lat3 T0 active", bus_active[1], 1'b1);
        chk("lat3 T0 addr", bus_addr[1], 10'h155);
        chk("lat3 T0 we_n", bus_we_n[1], 1'b1);
        cyc();
        m1_addr = 10'h3FF; m1_we_n = 0; bus_do = 8'hFF;
        smp();
        chk("lat3 T1 addr", bus_addr[1], 10'h155);
        chk("lat3 T1 we_n", bus_we_n[1], 1'b1);
        chk("lat3 T1 ack", m1_ack[1], 1'b0);
        cyc();
        smp();
        chk("lat3 T2 addr", bus_addr[1], 10'h155);
        chk("lat3 T2 ack", m1_ack[1], 1'b0);
        cyc();
        bus_do = 8'h5A;
        smp();
        chk("lat3 T3 addr", bus_addr[1], 10'h155);
        chk("lat3 T3 active", bus_active[1], 1'b1);
        chk("lat3 T3 ack", m1_ack[1], 1'b0);
        cyc();
        bus_do = 8'hEE;
        smp();
        chk("lat3 T4 m1_ack", m1_ack[1], 1'b1);
        chk("lat3 T4 m1_rdata", m1_rdata[1], 8'h5A);
        chk("lat3 T4 m0_ack", m0_ack[1], 1'b0);
        chk("lat3 T4 m0_rdata", m0_rdata[1], 8'h11);
        chk("lat3 T4 active", bus_active[1], 1'b0);
        cyc();
        m1_req = 0;
        smp();
        chk("lat3 after ack", m1_ack[1], 1'b0);
        chk("lat3 rdata held", m1_rdata[1], 8'h5A);

        // Tie from reset, then sustained contention
        do_reset();
        m0_req = 1; m0_we_n = 0; m1_req = 1; m1_we_n = 0;
        cyc();
        smp();
        chk("tie first owner", owner[0], 1'b0);
        chk("tie first owner rr", owner[2], 1'b0);
        dual = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            smp();
            if (m0_ack[0]) seq_a.push_back(0);
            if (m1_ack[0]) seq_a.push_back(1);
            if (m0_ack[2]) seq_c.push_back(0);
            if (m1_ack[2]) seq_c.push_back(1);
            if ((m0_ack[0] && m1_ack[0]) || (m0_ack[2] && m1_ack[2])) dual = 1;
        end
        chk("dual ack", dual, 1'b0);
        chk("burst4 enough grants", seq_a.size() >= 9, 1'b1);
        chk("burst1 enough grants", seq_c.size() >= 6, 1'b1);
        for (int i = 0; i < 9; i++)
            if (i < seq_a.size()) chk($sformatf("burst4 grant[%0d]", i), seq_a[i], exp_a[i]);
        for (int i = 0; i < 6; i++)
            if (i < seq_c.size()) chk($sformatf("burst1 grant[%0d]", i), seq_c[i], exp_c[i]);

        // Lone requester m1: 10 back-to-back writes, 3 cycles each
        do_reset();
        m1_req = 1; m1_we_n = 0; m1_addr = 10'h200; m1_wdata = 8'h00;
        k = 0; m0seen = 0;
        for (int c = 0; c < 32; c++) begin
            smp();
            acked = m1_ack[0];
            if (acked) begin
                chk($sformatf("lone ack[%0d] cycle", k), c, 2 + 3 * k);
                chk($sformatf("lone ack[%0d] bus_di", k), bus_di[0], m1_wdata);
                k++;
            end
            if (m0_ack[0]) m0seen = 1;
            cyc();
            if (acked) begin
                if (k == 10) m1_req = 0;
                m1_wdata = 8'(k);
                m1_addr = 10'h200 + 10'(k);
            end
        end
        chk("lone count", k, 10);
        chk("lone no m0 ack", m0seen, 1'b0);

        // Reset mid-write: we_n returns high without an edge
        do_reset();
        m0_req = 1; m0_we_n = 0; m0_addr = 10'h2AA; m0_wdata = 8'h33;
        cyc();
        smp();
        chk("rst write T0 we_n", bus_we_n[0], 1'b0);
        #1 rst_n = 0;
        #1;
        chk("rst async we_n", bus_we_n[0], 1'b1);
        chk("rst async active", bus_active[0], 1'b0);
        chk("rst async addr", bus_addr[0], 10'h000);

        // Reset during WAIT (RD_LATENCY=3), then a fresh grant
        do_reset();
        m0_req = 1; m0_we_n = 1; m0_addr = 10'h123;
        cyc();
        cyc();
        smp();
        chk("rst wait active pre", bus_active[1], 1'b1);
        #1 rst_n = 0;
        #1;
        chk("rst wait active", bus_active[1], 1'b0);
        chk("rst wait we_n", bus_we_n[1], 1'b1);
        chk("rst wait addr", bus_addr[1], 10'h000);
        m0_req = 0;
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            smp();
            if (m0_ack[1] || m1_ack[1]) seen = 1;
        end
        chk("rst no ack", seen, 1'b0);
        cyc();
        m1_req = 1; m1_we_n = 0; m1_addr = 10'h0F0; m1_wdata = 8'h77;
        cyc();
        smp();
        chk("post rst T0 we_n", bus_we_n[1], 1'b0);
        chk("post rst T0 addr", bus_addr[1], 10'h0F0);
        chk("post rst owner", owner[1], 1'b1);
        cyc();
        smp();
        chk("post rst m1_ack", m1_ack[1], 1'b1);
        chk("post rst m0_ack", m0_ack[1], 1'b0);
        cyc();
        m1_req = 0;

        // m0_req dropped during ACCESS still completes with one ack
        do_reset();
        m0_req = 1; m0_we_n = 0; m0_addr = 10'h001; m0_wdata = 8'h9C;
        cyc();
        m0_req = 0;
        smp();
        chk("drop T0 active", bus_active[0], 1'b1);
        n = 0; at = -1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            smp();
            if (m0_ack[0]) begin
                n++;
                if (at < 0) at = i;
            end
        end
        chk("drop ack count", n, 1);
        chk("drop ack cycle", at, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rriot_bus_arbiter.md
Name: rriot_bus_arbiter

Overview:
Two-port arbiter and sequencer that shares the single mcs6530 register/RAM/ROM bus between two requesters, e.g. a simulated CPU and a debug/loader port. It grants one requester per transaction, drives the 6530 address, data-in, we_n and RS0 lines, waits out the read latency, and returns read data with a one-cycle ack. A bounded-burst round-robin policy prevents either requester from starving the other.

Parameters:
RD_LATENCY, 1, cycles from first address-valid cycle to bus_do valid; legal range 1..7
MAX_BURST, 4, max consecutive grants to one owner while the other is requesting; legal range 1..15; 1 gives pure round-robin

Ports:
phi2  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  requester 0 transaction request, level; held until m0_ack
m0_we_n  input  1  requester 0: 0=write, 1=read
m0_rs0  input  1  requester 0 RS0 select
m0_addr  input  10  requester 0 address
m0_wdata  input  8  requester 0 write data
m0_ack  output  1  one-cycle completion pulse to requester 0
m0_rdata  output  8  requester 0 read data; valid while m0_ack=1 and held afterwards
m1_req, m1_we_n, m1_rs0, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for requester 1
bus_we_n  output  1  to mcs6530 we_n
bus_rs0  output  1  to mcs6530 RS0
bus_addr  output  10  to mcs6530 A
bus_di  output  8  to mcs6530 DI
bus_do  input  8  from mcs6530 DO
bus_active  output  1  high while a transaction owns the bus
owner  output  1  index of current or most recent owner

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bus_we_n=1, bus_rs0=0, bus_addr=0, bus_di=0, bus_active=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, owner=1, burst_cnt=MAX_BURST. bus_we_n goes high immediately, not at the next edge.
- State machine: IDLE -> ACCESS -> (WAIT x (RD_LATENCY) for reads) -> RESP -> IDLE.
- IDLE: bus_active=0, bus_we_n=1. On the rising edge:
  - If no req, stay in IDLE.
  - If exactly one req, grant it.
  - If both req: grant owner when burst_cnt < MAX_BURST; otherwise grant the other requester.
  - On grant: latch the winner's we_n/rs0/addr/wdata into the bus registers, set owner, go to ACCESS.
  - burst_cnt update on grant: same owner -> increment, saturating at MAX_BURST; different owner -> 1.
  - burst_cnt limits only tie cases; a lone requester is always granted.
- ACCESS (cycle T0): bus_active=1; bus_addr, bus_rs0 and bus_di hold the latched values.
  - Write: bus_we_n=0 during T0 only; the 6530 captures on the edge ending T0; next state RESP.
  - Read: bus_we_n=1; next state WAIT.
- WAIT: count RD_LATENCY cycles, T0+1..T0+RD_LATENCY.
  - Bus lines are held stable and bus_we_n=1.
  - bus_do is sampled on the edge ending cycle T0+RD_LATENCY into the owner's rdata register.
  - The non-owner's rdata is unchanged.
- RESP: exactly one cycle. owner's ack=1; bus_active=0; bus_we_n=1; bus_addr, bus_rs0 and bus_di keep their last values. Next state IDLE.
- Latency: write ack is in T0+1 (3 cycles per write including IDLE). Read ack is in T0+RD_LATENCY+1.
- Handshake:
  - The requester holds req and its fields until it samples ack.
  - In the cycle after ack (which is IDLE), the requester drops req or presents a new transaction.
  - The arbiter samples requests only in IDLE, so a stale req is never re-granted.
- Request fields are latched at grant; later changes to them are ignored until the next grant.
- A req that drops mid-transaction does not abort it: the transaction completes and ack still pulses.
- The two ack outputs are never high in the same cycle.
- Reset asserted mid-transaction: the bus returns to reset values immediately; no ack is issued; the transaction is lost.

Test Plan:
- Write then read: m0 writes addr=0x3C0, rs0=1, wdata=0xA5 -> bus_we_n=0 for exactly 1 cycle with bus_addr=0x3C0, bus_di=0xA5; m0_ack 1 cycle later. m0 then reads the same address -> m0_rdata=0xA5 with m0_ack at T0+2 (RD_LATENCY=1).
- RD_LATENCY=3 read: m1 reads with bus_do=0x5A presented from T0+3 -> bus_addr stable T0..T0+3; m1_ack at T0+4 with m1_rdata=0x5A; m0_rdata unchanged.
- Tie from reset: m0_req=m1_req=1 in the first IDLE -> m0 granted first (owner=0).
- Burst limit: both continuously requesting, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0… With MAX_BURST=1 -> strict 0,1,0,1.
- Lone requester: only m1 requests, 10 back-to-back writes -> all 10 granted, no gap beyond the IDLE cycle.
- Abort and drop:
  - rst_n pulsed low during WAIT -> bus_we_n=1 and bus_active=0 asynchronously; no ack; after release, the first IDLE grants fresh requests normally.
  - m0_req dropped during ACCESS -> m0_ack still pulses once.
